fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage of the MIPS datapath. It holds the PC, requests instructions from instruction memory over a req/ack handshake, and latches the instruction. It presents the imm16 field to the sign extender, then computes the next PC from the sign-extended branch offset that comes back, the jump target, or PC+4.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 0, max FETCH cycles without ack before error; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address (= pc)
imem_ack  input  1  memory has rdata valid this cycle
imem_rdata  input  32  instruction word from memory
instr  output  32  latched instruction
imm16  output  16  instr[15:0], feeds sign extender
instr_valid  output  1  instr is valid for execution
advance  input  1  core done with current instruction, one-cycle pulse
branch_taken  input  1  branch condition true, sampled with advance
branch_offset  input  32  sign-extended imm16 (word offset), sampled with advance
jump  input  1  j/jal, sampled with advance
pc  output  32  address of current instruction
pc_plus4  output  32  pc + 4, mod 2^32 (for jal link / branch base)
fetch_err  output  1  sticky fetch timeout flag

Behaviour:
- Reset: when rst_n=0 at a rising edge, the next cycle has pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, fetch_err=0, state=IDLE, timeout counter=0. Reset overrides all other inputs in every state.
- States: IDLE, FETCH, EXEC, ERR.
- IDLE: lasts one cycle after rst_n goes high, then goes to FETCH. imem_ack is ignored in IDLE.
- FETCH: imem_req=1 and imem_addr=pc. Both stay stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to EXEC.
  - Minimum latency: ack in the first FETCH cycle gives instr_valid on the following cycle.
- Timeout (TIMEOUT_CYCLES>0): a counter increments on each FETCH cycle without ack.
  - When TIMEOUT_CYCLES consecutive cycles pass without ack: fetch_err<=1, imem_req<=0, go to ERR.
  - The counter clears on ack or on leaving FETCH.
  - If ack arrives in the same cycle as the limit, the ack wins.
- EXEC: instr_valid=1, and instr/pc are held stable. On advance=1:
  - jump=1: next pc = {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - else branch_taken=1: next pc = pc_plus4 + (branch_offset << 2), 32-bit wraparound, overflow discarded.
  - else: next pc = pc_plus4.
  - Then: instr_valid<=0 next cycle, go to FETCH with the new pc.
- advance, branch_taken and jump are ignored outside EXEC.
- ERR: terminal. imem_req=0, instr_valid=0. Only reset exits.
- pc_plus4 is combinational from pc. imm16 is combinational from instr.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs retired_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - retired_cnt increments on each accepted advance.
  - stall_cnt increments on each FETCH cycle with imem_ack=0.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. RESET_PC=0, memory acks in the same cycle as req with rdata=0x2008000A -> imem_addr=0x0, instr=0x2008000A and instr_valid=1 one cycle after ack, imm16=0x000A.
2. Three advances with no branch or jump -> pc sequence 0x0, 0x4, 0x8, 0xC; instr_valid low for ≥1 cycle between instructions.
3. Branch at pc=0x40, branch_offset=0xFFFFFFFA (-6), branch_taken=1 -> next pc=0x2C. At pc=0x0 with offset=0x0000000A -> next pc=0x2C.
4. Jump at pc=0x00400000 with instr=0x08000010, jump=1 and branch_taken=1 -> next pc=0x00000040 (jump wins). Jump at pc=0xF0000000 -> next pc=0xF0000040.
5. Slow memory:
   - ack after 3 cycles -> imem_addr/imem_req stable all 3 cycles.
   - TIMEOUT_CYCLES=8 and no ack -> fetch_err=1 and imem_req=0 after 8 cycles, stays until reset.
6. rst_n low mid-FETCH at pc=0x20 -> next cycle imem_req=0, pc=RESET_PC; an ack arriving in the IDLE cycle is ignored (instr_valid stays 0).

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage. Holds the PC, fetches over a
// req/ack handshake, latches the instruction and computes the next PC
// (jump target, branch target or PC+4) when the core advances.
// Optional feature macro: FETCH_PERF_CNT_EN adds retired_cnt / stall_cnt.
module fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [15:0] imm16,
   output logic        instr_valid,
   input  logic        advance,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] retired_cnt,
   output logic [31:0] stall_cnt,
`endif
   output logic        fetch_err
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_e;

   localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] tmo_cnt_q, tmo_cnt_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [31:0] next_pc;

   assign pc_plus4    = pc_q + 32'd4;
   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign imem_req    = req_q;
   assign instr       = instr_q;
   assign imm16       = instr_q[15:0];
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;

   // Next-PC select for the instruction in EXEC: jump beats branch beats PC+4.
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (branch_taken) begin
         next_pc = pc_plus4 + (branch_offset << 2);
      end
   end

   // FSM next-state and registered-output logic; the timeout counter only
   // survives consecutive ack-less FETCH cycles, otherwise it falls back to zero.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      req_d     = req_q;
      valid_d   = valid_q;
      err_d     = err_q;
      tmo_cnt_d = '0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            req_d   = 1'b1;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = EXEC;
            end else if (TMO_EN && (tmo_cnt_q == TMO_LIMIT - 32'd1)) begin
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ERR;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
         end
         EXEC: begin
            if (advance) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = FETCH;
            end
         end
         ERR: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         req_q     <= req_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] retired_q, retired_d;
   logic [31:0] stall_q, stall_d;

   // Performance counters: accepted advances and ack-less FETCH cycles.
   always_comb begin
      retired_d = retired_q;
      stall_d   = stall_q;
      if (state_q == EXEC && advance) begin
         retired_d = retired_q + 32'd1;
      end
      if (state_q == FETCH && !imem_ack) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         retired_q <= retired_d;
         stall_q   <= stall_d;
      end
   end

   assign retired_cnt = retired_q;
   assign stall_cnt   = stall_q;
`endif

endmodule
